int_request_ctrl: RTL and testbench
===================================

Name: int_request_ctrl

Overview:
- Upstream interrupt front-end. Collects N_SRC external interrupt lines, edge-detects and latches them as pending, applies per-source masks and fixed priority.
- Issues a single-cycle request pulse to the interrupt detector's INT input, together with the handler vector for the selected source.
- Holds off further requests until the detector signals start of handler (start_int) and the handler completes (rti_done), so interrupts never overlap.

Parameters:
- N_SRC, 4, number of interrupt sources (1..8)
- ID_W, $clog2(N_SRC) (min 1), width of source index
- VEC_BASE, 16'h0000, handler vector address of source 0
- VEC_STRIDE, 16'h0002, vector spacing between consecutive sources

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- irq_in  in  N_SRC  raw interrupt lines, rising-edge triggered
- irq_mask  in  N_SRC  1 = source disabled from selection (still latches pending)
- int_en  in  1  global interrupt enable; 0 blocks new requests only
- start_int  in  1  one-cycle pulse from detector: handler entry reached
- rti_done  in  1  one-cycle pulse: handler returned
- int_req  out  1  one-cycle request pulse, drives detector INT
- int_vector  out  16  handler address of active source, stable from int_req until IDLE
- active_id  out  ID_W  index of active source
- in_service  out  1  high in SERVICE state
- pending  out  N_SRC  current pending latch

Behaviour:
- Reset (async, any state): state=IDLE; int_req=0, int_vector=0, active_id=0, in_service=0, pending=0, edge history=0.
- Edge detect: prev[i] is a register of the sampled irq_in. pending[i] sets at the posedge where irq_in[i]=1 and prev[i]=0. Level-high without an edge never re-sets pending.
- Eligible = pending & ~irq_mask. Winner = lowest eligible index.
- FSM states: IDLE, REQ, WAIT_ACK, SERVICE.
  - IDLE -> REQ when int_en=1 and eligible!=0. On this edge: int_req<=1, active_id<=winner, int_vector<=VEC_BASE+winner*VEC_STRIDE (16-bit, wraps mod 2^16), pending[winner] cleared.
  - REQ -> WAIT_ACK unconditionally next cycle; int_req<=0. int_req is high for exactly one cycle.
  - WAIT_ACK -> SERVICE on start_int=1; in_service<=1.
  - SERVICE -> IDLE on rti_done=1; in_service<=0. int_vector and active_id hold their values.
- Latency (no sync): edge sampled at posedge k -> pending at k; int_req high after posedge k+1 (if IDLE, int_en=1, unmasked).
- Earliest re-request: the cycle after returning to IDLE.
- Ignored inputs:
  - start_int outside WAIT_ACK.
  - rti_done outside SERVICE.
  - rti_done in WAIT_ACK (no state change).
- Simultaneous new edge on the winner during its clear cycle: set wins, pending stays 1.
- Edges arriving in REQ/WAIT_ACK/SERVICE latch into pending normally. A second edge on an already-pending source is absorbed (no counting).
- Masking or clearing int_en after IDLE->REQ does not cancel the in-flight request.

Optional Feature:
- Macro: INT_REQ_SYNC_EN.
- Defined: irq_in passes through a 2-flop synchronizer (reset to 0) before edge detection. Edge-to-int_req latency increases by 2 cycles (edge at posedge k -> int_req after posedge k+3).
- Undefined: irq_in is sampled directly. It must be synchronous to clk.

Decomposition:
- Shared package int_pkg:
  - state enum (IDLE, REQ, WAIT_ACK, SERVICE)
  - default VEC_BASE/VEC_STRIDE constants
  - function prio_pick(eligible) returning index and valid
- One sub-module int_edge_latch: per-source optional sync, edge detect, pending set/clear with set-priority, parameterised by N_SRC.
- FSM and vector generation stay in the top.

Test Plan:
- Reset mid-SERVICE with pending=4'b0110 -> all outputs 0, state IDLE next cycle; no int_req after release until a new edge.
- Single edge on irq_in[2], mask=0, int_en=1 -> int_req high 1 cycle, 2 cycles after the edge sample; int_vector=16'h0004; active_id=2; pending[2]=0. start_int -> in_service=1; rti_done -> in_service=0.
- Edges on sources 1 and 3 in the same cycle -> source 1 served first (vector 16'h0002); source 3 requested 1 cycle after rti_done (vector 16'h0006).
- Mask source 0, edge on 0 -> no int_req, pending[0]=1. Unmask -> int_req next cycle with vector 16'h0000.
- int_en=0 with pending source 1 -> no request. Stray start_int/rti_done in IDLE -> no state change. int_en=1 -> request issued.
- New edge on source 2 in the same cycle its pending is cleared -> pending[2] stays 1, second request follows after rti_done. With INT_REQ_SYNC_EN, first-request latency is 4 cycles.

Source files
------------

// File: rtl/int_pkg.sv
// Shared types, defaults and the fixed-priority picker for the interrupt request front-end.
package int_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_ACK,
        SERVICE
    } int_state_t;

    localparam logic [15:0] DEF_VEC_BASE   = 16'h0000;
    localparam logic [15:0] DEF_VEC_STRIDE = 16'h0002;
    localparam int          MAX_SRC        = 8;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } pick_t;

    // Scanning from the top down leaves the lowest eligible index as the winner.
    function automatic pick_t prio_pick(input logic [MAX_SRC-1:0] eligible);
        pick_t p;
        p.valid = 1'b0;
        p.idx   = 3'd0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                p.valid = 1'b1;
                p.idx   = 3'(i);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/int_edge_latch.sv
// Per-source rising-edge detect and pending latch; define INT_REQ_SYNC_EN to add
// a 2-flop synchronizer on the raw lines.
module int_edge_latch #(
    parameter int N_SRC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_in,
    input  logic [N_SRC-1:0] clr,
    output logic [N_SRC-1:0] pending
);

    logic [N_SRC-1:0] sampled;
    logic [N_SRC-1:0] prev;
    logic [N_SRC-1:0] rise;

`ifdef INT_REQ_SYNC_EN
    logic [N_SRC-1:0] sync1;
    logic [N_SRC-1:0] sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
        end
    end

    assign sampled = sync2;
`else
    assign sampled = irq_in;
`endif

    assign rise = sampled & ~prev;

    // A new edge landing in the same cycle as a clear keeps the source pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev    <= '0;
            pending <= '0;
        end else begin
            prev    <= sampled;
            pending <= (pending & ~clr) | rise;
        end
    end

endmodule

// File: rtl/int_request_ctrl.sv
// Interrupt request front-end: masks and prioritises pending sources, pulses int_req
// with the handler vector, then holds off until the handler returns. Optional macro: INT_REQ_SYNC_EN.
module int_request_ctrl
    import int_pkg::*;
#(
    parameter int          N_SRC      = 4,
    parameter int          ID_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1,
    parameter logic [15:0] VEC_BASE   = DEF_VEC_BASE,
    parameter logic [15:0] VEC_STRIDE = DEF_VEC_STRIDE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_in,
    input  logic [N_SRC-1:0] irq_mask,
    input  logic             int_en,
    input  logic             start_int,
    input  logic             rti_done,
    output logic             int_req,
    output logic [15:0]      int_vector,
    output logic [ID_W-1:0]  active_id,
    output logic             in_service,
    output logic [N_SRC-1:0] pending
);

    int_state_t       state;
    int_state_t       state_next;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] clr;
    logic             take;
    pick_t            pick;
    logic [15:0]      vec_next;

    int_edge_latch #(
        .N_SRC(N_SRC)
    ) u_edge_latch (
        .clk    (clk),
        .rst    (rst),
        .irq_in (irq_in),
        .clr    (clr),
        .pending(pending)
    );

    assign eligible = pending & ~irq_mask;
    assign pick     = prio_pick(MAX_SRC'(eligible));
    assign vec_next = VEC_BASE + 16'(pick.idx) * VEC_STRIDE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Only IDLE looks at int_en and the mask, so an issued request always runs to completion.
    always_comb begin
        state_next = state;
        take       = 1'b0;
        clr        = '0;
        case (state)
            IDLE: begin
                if (int_en && pick.valid) begin
                    state_next = REQ;
                    take       = 1'b1;
                    clr        = N_SRC'(1) << pick.idx;
                end
            end
            REQ:      state_next = WAIT_ACK;
            WAIT_ACK: if (start_int) state_next = SERVICE;
            SERVICE:  if (rti_done) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_req    <= 1'b0;
            int_vector <= 16'h0000;
            active_id  <= '0;
            in_service <= 1'b0;
        end else begin
            int_req    <= take;
            in_service <= (state_next == SERVICE);
            if (take) begin
                active_id  <= pick.idx[ID_W-1:0];
                int_vector <= vec_next;
            end
        end
    end

endmodule

// File: tb/tb_int_request_ctrl.sv
// Scoreboard bench for int_request_ctrl: directed vectors push expected requests,
// an independent monitor pops and checks every int_req pulse.
module tb_int_request_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  irq_in = '0;
    logic [3:0]  irq_mask = '0;
    logic        int_en = 1'b0;
    logic        start_int = 1'b0;
    logic        rti_done = 1'b0;
    logic        int_req;
    logic [15:0] int_vector;
    logic [1:0]  active_id;
    logic        in_service;
    logic [3:0]  pending;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] vec;
        int          id;
        int          due;
    } exp_t;

    exp_t sb[$];

`ifdef INT_REQ_SYNC_EN
    localparam int         LAT         = 4;
    localparam logic [3:0] SETWIN_PEND = 4'b0000;
`else
    localparam int         LAT         = 2;
    localparam logic [3:0] SETWIN_PEND = 4'b0100;
`endif

    int_request_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .irq_mask  (irq_mask),
        .int_en    (int_en),
        .start_int (start_int),
        .rti_done  (rti_done),
        .int_req   (int_req),
        .int_vector(int_vector),
        .active_id (active_id),
        .in_service(in_service),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [3:0] irq, input logic [3:0] mask, input logic en);
        irq_in   = irq;
        irq_mask = mask;
        int_en   = en;
    endtask

    task automatic expectReq(input logic [15:0] vec, input int id, input int due);
        exp_t e;
        e.vec = vec;
        e.id  = id;
        e.due = due;
        sb.push_back(e);
    endtask

    // Returns at the falling edge where int_req is seen high, or after the budget runs out.
    task automatic waitReq(input string name, input logic [3:0] exp_pending);
        bit found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (int_req) found = 1;
        end
        checkOutput(name, int'(int_req), 1);
        if (found) checkOutput({name, "_pending"}, int'(pending), int'(exp_pending));
    endtask

    task automatic ackStart();
        step(1);
        start_int = 1'b1;
        step(1);
        start_int = 1'b0;
        checkOutput("in_service_set", int'(in_service), 1);
    endtask

    task automatic ackDone(output int rc);
        rti_done = 1'b1;
        rc = cyc;
        step(1);
        rti_done = 1'b0;
        checkOutput("in_service_clr", int'(in_service), 0);
    endtask

    // Monitor: every int_req pulse must be single-cycle and match the head of the scoreboard.
    initial begin : monitor
        logic prev_req;
        exp_t e;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (int_req) begin
                checkOutput("req_single_cycle", int'(prev_req), 0);
                if (sb.size() == 0) begin
                    checkOutput("unexpected_req", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    checkOutput("req_vector", int'(int_vector), int'(e.vec));
                    checkOutput("req_id", int'(active_id), e.id);
                    checkOutput("req_cycle", cyc, e.due);
                end
            end
            prev_req = int_req;
        end
    end

    initial begin : stimulus
        int rc;

        // Reset state
        step(2);
        checkOutput("rst_int_req", int'(int_req), 0);
        checkOutput("rst_vector", int'(int_vector), 0);
        checkOutput("rst_id", int'(active_id), 0);
        checkOutput("rst_in_service", int'(in_service), 0);
        checkOutput("rst_pending", int'(pending), 0);
        rst = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        step(2);

        // Single edge on source 2
        applyStimulus(4'b0100, 4'b0000, 1'b1);
        expectReq(16'h0004, 2, cyc + LAT);
        waitReq("single_req", 4'b0000);
        ackStart();
        checkOutput("single_id", int'(active_id), 2);
        checkOutput("single_vec", int'(int_vector), 16'h0004);
        ackDone(rc);
        checkOutput("single_vec_hold", int'(int_vector), 16'h0004);
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        step(LAT + 2);

        // Sources 1 and 3 together: 1 first, 3 one cycle after return to IDLE
        applyStimulus(4'b1010, 4'b0000, 1'b1);
        expectReq(16'h0002, 1, cyc + LAT);
        waitReq("dual_first", 4'b1000);
        ackStart();
        ackDone(rc);
        expectReq(16'h0006, 3, rc + 2);
        waitReq("dual_second", 4'b0000);
        ackStart();
        ackDone(rc);
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        step(LAT + 2);

        // Masked source 0 latches but does not request until unmasked
        applyStimulus(4'b0001, 4'b0001, 1'b1);
        step(LAT + 3);
        checkOutput("mask_pending", int'(pending), 4'b0001);
        checkOutput("mask_no_req", int'(int_req), 0);
        applyStimulus(4'b0001, 4'b0000, 1'b1);
        expectReq(16'h0000, 0, cyc + 1);
        waitReq("unmask_req", 4'b0000);
        ackStart();
        ackDone(rc);
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        step(LAT + 2);

        // Global disable with stray handshakes in IDLE
        applyStimulus(4'b0010, 4'b0000, 1'b0);
        step(LAT + 3);
        start_int = 1'b1;
        step(1);
        start_int = 1'b0;
        rti_done = 1'b1;
        step(1);
        rti_done = 1'b0;
        step(1);
        checkOutput("dis_pending", int'(pending), 4'b0010);
        checkOutput("dis_in_service", int'(in_service), 0);
        checkOutput("dis_no_req", int'(int_req), 0);
        applyStimulus(4'b0010, 4'b0000, 1'b1);
        expectReq(16'h0002, 1, cyc + 1);
        waitReq("enable_req", 4'b0000);
        ackStart();
        ackDone(rc);
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        step(LAT + 2);

        // New edge on source 2 in the cycle its pending bit is cleared
        applyStimulus(4'b0100, 4'b0000, 1'b0);
        step(LAT + 2);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        step(LAT + 2);
        checkOutput("setwin_preload", int'(pending), 4'b0100);
        applyStimulus(4'b0100, 4'b0000, 1'b1);
        expectReq(16'h0004, 2, cyc + 1);
        waitReq("setwin_first", SETWIN_PEND);
        ackStart();
        checkOutput("setwin_relatched", int'(pending), 4'b0100);
        ackDone(rc);
        expectReq(16'h0004, 2, rc + 2);
        waitReq("setwin_second", 4'b0000);
        ackStart();
        ackDone(rc);
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        step(LAT + 2);

        // Asynchronous reset in SERVICE with sources 1 and 2 still pending
        applyStimulus(4'b1110, 4'b0111, 1'b1);
        expectReq(16'h0006, 3, cyc + LAT);
        waitReq("rst_setup", 4'b0110);
        applyStimulus(4'b1110, 4'b0000, 1'b1);
        ackStart();
        rst = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        #1;
        checkOutput("arst_int_req", int'(int_req), 0);
        checkOutput("arst_vector", int'(int_vector), 0);
        checkOutput("arst_id", int'(active_id), 0);
        checkOutput("arst_in_service", int'(in_service), 0);
        checkOutput("arst_pending", int'(pending), 0);
        step(2);
        rst = 1'b0;
        step(LAT + 4);
        checkOutput("post_rst_pending", int'(pending), 0);
        checkOutput("post_rst_in_service", int'(in_service), 0);
        checkOutput("post_rst_int_req", int'(int_req), 0);

        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
